// File: rtl/elastic_buffer_if.sv
// Handshake bundle for elastic_buffer: upstream push side, downstream pop side,
// plus flush and occupancy status. The buffer connects to the slave modport.
interface elastic_buffer_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  logic                         flush;
  logic                         in_valid;
  logic                         in_ready;
  logic [WIDTH-1:0]             in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [WIDTH-1:0]             out_data;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         almost_full;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count, almost_full
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count, almost_full
  );
endinterface

// File: rtl/elastic_buffer.sv
// Elastic buffer: DEPTH-entry circular FIFO with one-cycle latency, no
// bypass, registered-only ready/valid outputs and a synchronous flush.
module elastic_buffer #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = DEPTH - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  elastic_buffer_if.slave  bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_LVL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  logic push;
  logic pop;

  // Ready/valid come straight from the occupancy register, so neither
  // in_valid nor out_ready can reach in_ready or out_valid combinationally.
  assign bus.in_ready    = (count_q < FULL_CNT);
  assign bus.out_valid   = (count_q != '0);
  assign bus.out_data    = mem[rd_ptr];
  assign bus.count       = count_q;
  assign bus.almost_full = (count_q >= AFULL_CNT);

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // Control state: reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage is not reset; a word offered during reset or flush is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && !bus.flush && push) mem[wr_ptr] <= bus.in_data;
  end
endmodule
